// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks E/M/W destination state to drive operand forwarding,
// one-cycle load-use stalls and branch flushes, plus saturating stall/flush counters.
module hazard_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             PCSrcE,
  output logic [1:0]       mux_rd1_E,
  output logic [1:0]       mux_rd2_E,
  output logic             en_fetch,
  output logic             en_decode,
  output logic             flush_D,
  output logic             flush_E,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned REG_W    = 5;
  localparam logic [1:0]  RES_LOAD = 2'b01;
  localparam logic [1:0]  FWD_NONE = 2'b00;
  localparam logic [1:0]  FWD_W    = 2'b01;
  localparam logic [1:0]  FWD_M    = 2'b10;

  logic [REG_W-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic             reg_write_e, reg_write_m, reg_write_w;
  logic [1:0]       result_src_e;
  logic             lwstall;
  logic             stall_inc;

  // M-stage match wins over W; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rdm,
    input logic             rwm,
    input logic [REG_W-1:0] rdw,
    input logic             rww
  );
    logic [1:0] sel;
    sel = FWD_NONE;
    if (rwm && (rdm != '0) && (rdm == rs))      sel = FWD_M;
    else if (rww && (rdw != '0) && (rdw == rs)) sel = FWD_W;
    return sel;
  endfunction

  always_comb begin
    lwstall   = 1'b0;
    mux_rd1_E = FWD_NONE;
    mux_rd2_E = FWD_NONE;
    en_fetch  = 1'b1;
    en_decode = 1'b1;
    flush_D   = 1'b0;
    flush_E   = 1'b0;
    stall_inc = 1'b0;

    lwstall   = (result_src_e == RES_LOAD) && (rd_e != '0) &&
                ((rd_e == Rs1D) || (rd_e == Rs2D));
    mux_rd1_E = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    mux_rd2_E = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

    // A taken branch squashes the stalled instruction, so the stall is dropped.
    en_fetch  = ~lwstall | PCSrcE;
    en_decode = ~lwstall | PCSrcE;
    flush_D   = PCSrcE;
    flush_E   = lwstall | PCSrcE;
    stall_inc = lwstall & ~PCSrcE;
  end

  // Shadow pipeline: E takes a bubble when flushed; M and W always advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      reg_write_e  <= 1'b0;
      result_src_e <= 2'b00;
      rd_m         <= '0;
      reg_write_m  <= 1'b0;
      rd_w         <= '0;
      reg_write_w  <= 1'b0;
    end else begin
      if (flush_E) begin
        rs1_e        <= '0;
        rs2_e        <= '0;
        rd_e         <= '0;
        reg_write_e  <= 1'b0;
        result_src_e <= 2'b00;
      end else begin
        rs1_e        <= Rs1D;
        rs2_e        <= Rs2D;
        rd_e         <= RdD;
        reg_write_e  <= RegWriteD;
        result_src_e <= ResultSrcD;
      end
      rd_m        <= rd_e;
      reg_write_m <= reg_write_e;
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (PCSrcE && (flush_cnt != '1))    flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load-use stall, branch priority,
// x0 handling, counter saturation and asynchronous reset.
module tb_hazard_unit;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset;
  logic [4:0]    Rs1D, Rs2D, RdD;
  logic          RegWriteD;
  logic [1:0]    ResultSrcD;
  logic          PCSrcE;
  logic [1:0]    mux_rd1_E, mux_rd2_E;
  logic          en_fetch, en_decode, flush_D, flush_E;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  hazard_unit #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdD        (RdD),
    .RegWriteD  (RegWriteD),
    .ResultSrcD (ResultSrcD),
    .PCSrcE     (PCSrcE),
    .mux_rd1_E  (mux_rd1_E),
    .mux_rd2_E  (mux_rd2_E),
    .en_fetch   (en_fetch),
    .en_decode  (en_decode),
    .flush_D    (flush_D),
    .flush_E    (flush_E),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic [1:0] rsrc, input logic pcs);
    Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; ResultSrcD = rsrc; PCSrcE = pcs;
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mux1"}, 16'(mux_rd1_E), 16'h0);
    chk({tag, "_mux2"}, 16'(mux_rd2_E), 16'h0);
    chk({tag, "_enf"},  16'(en_fetch),  16'h1);
    chk({tag, "_end"},  16'(en_decode), 16'h1);
    chk({tag, "_fld"},  16'(flush_D),   16'h0);
    chk({tag, "_fle"},  16'(flush_E),   16'h0);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 2'b00, 0);
    #20;
    chk_idle("rst");
    chk("rst_scnt", 16'(stall_cnt), 16'h0);
    chk("rst_fcnt", 16'(flush_cnt), 16'h0);
    tick();
    reset = 1'b1;
    #1;
    chk_idle("post_rst");

    // add x5 -> add using x5 (M forward) -> use x5 on Rs2 (W forward)
    drive(0, 0, 5, 1, 2'b00, 0); tick();
    drive(5, 0, 6, 1, 2'b00, 0); tick();
    chk("fwd_m_rs1", 16'(mux_rd1_E), 16'h2);
    drive(0, 5, 0, 0, 2'b00, 0); tick();
    chk("fwd_w_rs2", 16'(mux_rd2_E), 16'h1);
    chk("fwd_w_rs1", 16'(mux_rd1_E), 16'h0);

    // same Rd in M and W: M wins
    drive(0, 0, 5, 1, 2'b00, 0); tick();
    drive(0, 0, 5, 1, 2'b00, 0); tick();
    drive(5, 0, 0, 0, 2'b00, 0); tick();
    chk("m_prio", 16'(mux_rd1_E), 16'h2);

    // writes to x0 are never forwarded
    drive(0, 0, 0, 1, 2'b00, 0); tick();
    drive(0, 0, 0, 1, 2'b00, 0); tick();
    chk("x0_fwd1", 16'(mux_rd1_E), 16'h0);
    chk("x0_fwd2", 16'(mux_rd2_E), 16'h0);
    drive(0, 0, 0, 0, 2'b00, 0); tick(); tick(); tick();

    // lw x7 then use on Rs2: one stall cycle, then W forward
    drive(0, 0, 7, 1, 2'b01, 0); tick();
    drive(0, 7, 8, 1, 2'b00, 0);
    chk("lw_enf",  16'(en_fetch),  16'h0);
    chk("lw_end",  16'(en_decode), 16'h0);
    chk("lw_fle",  16'(flush_E),   16'h1);
    chk("lw_fld",  16'(flush_D),   16'h0);
    tick();
    chk("lw_scnt", 16'(stall_cnt), 16'h1);
    chk("lw_enf2", 16'(en_fetch),  16'h1);
    chk("lw_fle2", 16'(flush_E),   16'h0);
    chk("lw_bub2", 16'(mux_rd2_E), 16'h0);
    tick();
    chk("lw_fwdw", 16'(mux_rd2_E), 16'h1);
    chk("lw_scnt2", 16'(stall_cnt), 16'h1);

    // lw x0 never stalls
    drive(0, 0, 0, 1, 2'b01, 0); tick();
    drive(0, 0, 0, 0, 2'b00, 0);
    chk("lw0_enf", 16'(en_fetch), 16'h1);
    chk("lw0_fle", 16'(flush_E),  16'h0);
    tick();
    chk("lw0_mux", 16'(mux_rd1_E), 16'h0);
    chk("lw0_scnt", 16'(stall_cnt), 16'h1);

    // branch coincident with load-use: branch wins, stall discarded
    drive(0, 0, 9, 1, 2'b01, 0); tick();
    drive(9, 0, 0, 0, 2'b00, 1);
    chk("br_fld", 16'(flush_D),   16'h1);
    chk("br_fle", 16'(flush_E),   16'h1);
    chk("br_enf", 16'(en_fetch),  16'h1);
    chk("br_end", 16'(en_decode), 16'h1);
    tick();
    chk("br_fcnt", 16'(flush_cnt), 16'h1);
    chk("br_scnt", 16'(stall_cnt), 16'h1);
    drive(0, 0, 0, 0, 2'b00, 0);
    chk("br_fld0", 16'(flush_D), 16'h0);

    // 20 more stall cycles saturate the 4-bit counter at 15
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 3, 1, 2'b01, 0); tick();
      drive(3, 0, 0, 0, 2'b00, 0); tick();
      if (i == 13) chk("sat_s15", 16'(stall_cnt), 16'hF);
    end
    chk("sat_scnt", 16'(stall_cnt), 16'hF);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 2'b00, 1); tick();
    end
    chk("sat_fcnt", 16'(flush_cnt), 16'hF);

    // reset asserted mid-stall clears everything without a clock edge
    drive(0, 0, 3, 1, 2'b01, 0); tick();
    drive(3, 0, 0, 0, 2'b00, 0);
    chk("mid_stall", 16'(en_fetch), 16'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_scnt", 16'(stall_cnt), 16'h0);
    chk("arst_fcnt", 16'(flush_cnt), 16'h0);
    chk_idle("arst");
    tick();
    reset = 1'b1;
    #1;
    tick();
    chk("post_arst_scnt", 16'(stall_cnt), 16'h0);
    chk("post_arst_enf",  16'(en_fetch),  16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
